// File: rtl/mem_upload_pkg.sv
// mem_upload_pkg: shared FSM states, region map and fill byte for the upload block
package mem_upload_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, CAPT} state_e;
  localparam logic [26:0] REG1_BASE = 27'h0000000;
  localparam logic [26:0] REG2_BASE = 27'h0010000;
  localparam logic [26:0] REG_LIMIT = 27'h0020000;
  localparam logic [7:0]  FILL_BYTE = 8'hFF;
endpackage

// File: rtl/mem_upload_region_dec.sv
// upload_region_dec: maps an upload byte address to a one-hot RAM select and local address
module upload_region_dec
  import mem_upload_pkg::*;
(
  input  logic [26:0] addr_i,
  output logic [1:0]  sel_o,
  output logic [15:0] addr_o
);
  // Region 1 below REG2_BASE, region 2 up to REG_LIMIT, nothing above (reads return FILL_BYTE)
  always_comb begin
    sel_o  = addr_i < REG2_BASE ? 2'b01 : addr_i < REG_LIMIT ? 2'b10 : 2'b00;
    addr_o = addr_i[15:0] - (sel_o[1] ? REG2_BASE[15:0] : REG1_BASE[15:0]);
  end
endmodule

// File: rtl/mem_upload.sv
// mem_upload: serves HPS upload word reads from two byte RAMs (optional UPLOAD_CKSUM_EN adds cksum)
module mem_upload
  import mem_upload_pkg::*;
#(
  parameter logic [7:0] UPL_INDEX = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic [26:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [1:0]  mem_sel,
  input  logic [7:0]  mem1_q,
  input  logic [7:0]  mem2_q,
`ifdef UPLOAD_CKSUM_EN
  output logic [15:0] cksum,
`endif
  output logic        busy
);
  state_e      state_q, state_d;
  logic [26:0] addr_q;
  logic [7:0]  lo_q, hi_q;
  logic        done_q, wait_q;
  logic [15:0] din_q, maddr_q;
  logic [1:0]  sel_q;
  logic        start, abort;
  logic [26:0] dec_a;
  logic [1:0]  dec_sel;
  logic [15:0] dec_addr;
  logic [7:0]  byte_in;
  // done_q marks the extra delivery cycle after CAPT; no new request is taken while it is pending
  assign start   = ioctl_upload && ioctl_index == UPL_INDEX && ioctl_rd && state_q == IDLE && !done_q;
  assign abort   = state_q != IDLE && !ioctl_upload;
  assign dec_a   = state_q == IDLE ? (ioctl_addr & ~27'd1) : (addr_q | 27'd1);
  assign byte_in = sel_q[0] ? mem1_q : sel_q[1] ? mem2_q : FILL_BYTE;
  upload_region_dec u_dec (.addr_i(dec_a), .sel_o(dec_sel), .addr_o(dec_addr));
  // Fetch sequencer: one state per cycle, upload drop returns straight to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? LO : IDLE;
      LO:      state_d = HI;
      HI:      state_d = CAPT;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // Address/select drive, byte capture and word delivery
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
      wait_q  <= 1'b0;
      din_q   <= '0;
      maddr_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == CAPT && !abort;
      if (start) begin
        addr_q  <= dec_a;
        maddr_q <= dec_addr;
        sel_q   <= dec_sel;
        wait_q  <= 1'b1;
      end else if (abort) begin
        sel_q  <= '0;
        wait_q <= 1'b0;
      end else if (state_q == LO) begin
        maddr_q <= dec_addr;
        sel_q   <= dec_sel;
      end else if (state_q == HI) begin
        lo_q <= byte_in;
      end else if (state_q == CAPT) begin
        hi_q  <= byte_in;
        sel_q <= '0;
      end
      if (done_q) begin
        wait_q <= 1'b0;
        if (ioctl_upload) din_q <= {hi_q, lo_q};
      end
    end
  end
`ifdef UPLOAD_CKSUM_EN
  logic        up_q;
  logic [15:0] cksum_q;
  // Running byte sum of delivered words, restarted when a matching upload session begins
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      up_q    <= 1'b0;
      cksum_q <= '0;
    end else begin
      up_q <= ioctl_upload;
      if (ioctl_upload && !up_q && ioctl_index == UPL_INDEX) cksum_q <= '0;
      else if (done_q && ioctl_upload) cksum_q <= cksum_q + {8'h00, lo_q} + {8'h00, hi_q};
    end
  end
  assign cksum = cksum_q;
`endif
  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_addr   = maddr_q;
  assign mem_sel    = sel_q;
  assign busy       = state_q != IDLE;
endmodule

// File: doc/mem_upload.md
MEM_UPLOAD -- requirements
Module: mem_upload

Interface
REQ-001 SHALL have parameter UPL_INDEX, default 8'd0, the ioctl_index value this block serves.
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ioctl_upload  input  1  HPS upload session active.
REQ-005 SHALL have port ioctl_index  input  8  selected image index.
REQ-006 SHALL have port ioctl_addr  input  27  byte address of the requested word.
REQ-007 SHALL have port ioctl_rd  input  1  single-cycle read request strobe.
REQ-008 SHALL have port ioctl_din  output  16  returned word, little-endian.
REQ-009 SHALL have port ioctl_wait  output  1  stall to HPS while a fetch is in progress.
REQ-010 SHALL have port mem_addr  output  16  registered byte address to the target RAM.
REQ-011 SHALL have port mem_sel  output  2  registered one-hot region select: [0] region 1, [1] region 2.
REQ-012 SHALL have ports mem1_q and mem2_q  input  8 each  RAM read data, valid one cycle after mem_addr.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL accept a request only when ioctl_upload=1, ioctl_index=UPL_INDEX, state=IDLE and ioctl_rd=1 at edge N; ioctl_addr bit 0 is forced to 0 when latched.
REQ-015 SHALL run the FSM IDLE -> LO -> HI -> CAPT -> IDLE, one state per cycle, with no other transitions except those in REQ-021.
REQ-016 SHALL, in LO, drive mem_addr=A and, in HI, drive mem_addr=A+1; it SHALL capture the low byte at the end of HI and the high byte at the end of CAPT.
REQ-017 SHALL raise ioctl_wait at edge N, hold it high through LO, HI and CAPT, and clear it at edge N+4, the same edge that updates ioctl_din.
REQ-018 SHALL decode regions as follows:
- A<0x10000: region 1, mem_addr=A[15:0].
- 0x10000<=A<0x20000: region 2, mem_addr=A-0x10000.
- A>=0x20000: mem_sel=0, and each byte returns 0xFF.
REQ-019 SHALL hold mem_sel=0 in IDLE; mem_addr SHALL hold its last value.
REQ-020 SHALL ignore ioctl_rd while state is not IDLE, including a strobe that arrives in the same cycle wait rises.
REQ-021 SHALL abort to IDLE on the next edge if ioctl_upload falls mid-fetch: ioctl_wait=0, mem_sel=0, and ioctl_din keeps its previous value.
REQ-022 SHALL hold ioctl_din stable between updates.

Reset
REQ-023 SHALL, on reset, set state=IDLE, ioctl_din=16'h0000, ioctl_wait=0, mem_addr=0, mem_sel=0, busy=0, and clear any latched address.
REQ-024 SHALL give reset priority over all other events, including a concurrent ioctl_rd.

Configuration
REQ-025 SHALL, with UPLOAD_CKSUM_EN defined, provide an output cksum (16 bits) that behaves as follows:
- Cleared to 0 on reset and on the cycle ioctl_upload rises while the index matches.
- Incremented modulo 2^16 at each completed word by both delivered bytes, zero-extended.
- Unchanged on aborted fetches.
REQ-026 SHALL, without UPLOAD_CKSUM_EN, omit the cksum port and its logic entirely, with all other behaviour identical.

Structure
REQ-027 SHALL place the following in a shared package:
- The FSM state enum.
- Region base constants 0x00000, 0x10000 and limit 0x20000.
- Fill byte 0xFF.
REQ-028 SHALL implement region decoding (REQ-018) in one combinational sub-module, upload_region_dec, instantiated once.

Verification
REQ-029 SHALL cover these directed scenarios:
- mem1[0x1234]=0xAB, mem1[0x1235]=0xCD; ioctl_rd with addr 0x01234 -> wait high 4 cycles, then ioctl_din=0xCDAB and wait low.
- mem2[0x0010]=0x11, mem2[0x0011]=0x22; addr 0x10010 -> mem_sel=2'b10, ioctl_din=0x2211.
- addr 0x20000 -> mem_sel stays 0, ioctl_din=0xFFFF, same 4-cycle latency.
- Second ioctl_rd during HI -> ignored; exactly one fetch completes.
- ioctl_upload dropped during HI -> IDLE next cycle, wait=0, ioctl_din unchanged; reset during LO -> all outputs at reset values.
- UPLOAD_CKSUM_EN defined: words 0xCDAB then 0x2211 -> cksum=0x01AB.
